// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - DLX instruction-fetch stage: PC, IF/ID register, stall/redirect/trap-halt
//
// Holds the program counter, presents it to instruction memory, and latches
// the returned word together with PC+4 into the IF/ID register for decode.
// Redirects from later stages override stalls; a redirect squashes the
// wrong-path word and costs exactly one bubble.
//
// Optional feature macro: IF_TRAP_HALT_EN
//   defined     - a fetched TRAP_INSTR is latched normally, then fetch parks
//                 at the trap address in HALTED until a redirect or reset.
//   not defined - no trap detection; halted_out is tied low.
//
// Ports (vectors are [0:SIZE-1], bit 0 = MSB):
//   clk             - clock, rising edge
//   reset           - asynchronous, active-low
//   stall_in        - hold PC and IF/ID
//   redirect_in     - taken branch/jump resolved downstream
//   redirectPC_in   - redirect target (low two bits ignored)
//   imem_addr_out   - instruction-memory address (current PC)
//   imem_data_in    - instruction word at imem_addr_out, same cycle
//   instruction_out - IF/ID instruction
//   nextPC_out      - IF/ID PC+4
//   valid_out       - IF/ID holds a real instruction
//   halted_out      - fetch is halted after a trap
//   fetch_count_out - valid instructions latched since reset (wraps)

module instruction_fetch #(
    parameter int               SIZE       = 32,
    parameter logic [0:SIZE-1]  RESET_PC   = 32'h00000000,
    parameter logic [0:SIZE-1]  NOP_INSTR  = 32'h00000000,
    parameter logic [0:SIZE-1]  TRAP_INSTR = 32'h44000300
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [0:SIZE-1] redirectPC_in,
    output logic [0:SIZE-1] imem_addr_out,
    input  logic [0:SIZE-1] imem_data_in,
    output logic [0:SIZE-1] instruction_out,
    output logic [0:SIZE-1] nextPC_out,
    output logic            valid_out,
    output logic            halted_out,
    output logic [0:31]     fetch_count_out
);

    localparam logic [0:SIZE-1] ALIGN_MASK = ~(SIZE'(3));

    logic [0:SIZE-1] pc_q,    pc_nxt;
    logic [0:SIZE-1] instr_q, instr_nxt;
    logic [0:SIZE-1] npc_q,   npc_nxt;
    logic            valid_q, valid_nxt;
    logic [0:31]     count_q, count_nxt;
    logic [0:SIZE-1] pc_plus4;

`ifdef IF_TRAP_HALT_EN
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
    state_t state_q, state_nxt;
`else
    // Trap encoding is only meaningful when the halt feature is built in.
    logic unused_trap_instr;
    assign unused_trap_instr = ^TRAP_INSTR;
`endif

    assign pc_plus4 = pc_q + SIZE'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
`ifdef IF_TRAP_HALT_EN
            state_q <= RUN;
`endif
        end else begin
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            npc_q   <= npc_nxt;
            valid_q <= valid_nxt;
            count_q <= count_nxt;
`ifdef IF_TRAP_HALT_EN
            state_q <= state_nxt;
`endif
        end
    end

    always_comb begin
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        npc_nxt   = npc_q;
        valid_nxt = valid_q;
        count_nxt = count_q;
`ifdef IF_TRAP_HALT_EN
        state_nxt = state_q;
`endif
        if (redirect_in) begin
            // Redirect wins over stall; the word fetched this cycle is wrong-path.
            pc_nxt    = redirectPC_in & ALIGN_MASK;
            instr_nxt = NOP_INSTR;
            npc_nxt   = '0;
            valid_nxt = 1'b0;
`ifdef IF_TRAP_HALT_EN
            state_nxt = RUN;
`endif
        end else if (stall_in) begin
            // Everything holds.
`ifdef IF_TRAP_HALT_EN
        end else if (state_q == HALTED) begin
            instr_nxt = NOP_INSTR;
            npc_nxt   = '0;
            valid_nxt = 1'b0;
`endif
        end else begin
            instr_nxt = imem_data_in;
            npc_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            count_nxt = count_q + 32'd1;
            pc_nxt    = pc_plus4;
`ifdef IF_TRAP_HALT_EN
            // The trap itself is delivered; fetch then parks on its address.
            if (imem_data_in == TRAP_INSTR) begin
                pc_nxt    = pc_q;
                state_nxt = HALTED;
            end
`endif
        end
    end

    assign imem_addr_out   = pc_q;
    assign instruction_out = instr_q;
    assign nextPC_out      = npc_q;
    assign valid_out       = valid_q;
    assign fetch_count_out = count_q;
`ifdef IF_TRAP_HALT_EN
    assign halted_out      = (state_q == HALTED);
`else
    assign halted_out      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table-driven bench for instruction_fetch

module tb_instruction_fetch;

`ifdef IF_TRAP_HALT_EN
    localparam bit T = 1'b1;
`else
    localparam bit T = 1'b0;
`endif
    localparam logic [31:0] TRAP = 32'h44000300;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [0:31] redirectPC_in;
    logic [0:31] imem_addr_out;
    logic [0:31] imem_data_in;
    logic [0:31] instruction_out;
    logic [0:31] nextPC_out;
    logic        valid_out;
    logic        halted_out;
    logic [0:31] fetch_count_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .redirect_in     (redirect_in),
        .redirectPC_in   (redirectPC_in),
        .imem_addr_out   (imem_addr_out),
        .imem_data_in    (imem_data_in),
        .instruction_out (instruction_out),
        .nextPC_out      (nextPC_out),
        .valid_out       (valid_out),
        .halted_out      (halted_out),
        .fetch_count_out (fetch_count_out)
    );

    // Memory: word at address a is 0xA0 + a/4, except a trap word at 0x20.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20) return TRAP;
        return 32'hA0 + (a >> 2);
    endfunction

    assign imem_data_in = mem_word(imem_addr_out);

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        halted;
        logic [31:0] count;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] npc, input logic v, input logic h,
                                input logic [31:0] cnt);
        vec_t x;
        x.stall = s; x.redir = r; x.rpc = rpc; x.addr = addr; x.instr = instr;
        x.npc = npc; x.valid = v; x.halted = h; x.count = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] npc, input logic v, input logic h,
                           input logic [31:0] cnt);
        chk({tag, "_addr"},   imem_addr_out,   addr);
        chk({tag, "_instr"},  instruction_out, instr);
        chk({tag, "_npc"},    nextPC_out,      npc);
        chk({tag, "_valid"},  {31'b0, valid_out},  {31'b0, v});
        chk({tag, "_halted"}, {31'b0, halted_out}, {31'b0, h});
        chk({tag, "_count"},  fetch_count_out, cnt);
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        stall_in      = s;
        redirect_in   = r;
        redirectPC_in = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,            32'h4,   32'hA0, 32'h4,  1,0, 1);
        vecs[1]  = mk(0,0,0,            32'h8,   32'hA1, 32'h8,  1,0, 2);
        vecs[2]  = mk(1,0,0,            32'h8,   32'hA1, 32'h8,  1,0, 2);
        vecs[3]  = mk(1,0,0,            32'h8,   32'hA1, 32'h8,  1,0, 2);
        vecs[4]  = mk(1,0,0,            32'h8,   32'hA1, 32'h8,  1,0, 2);
        vecs[5]  = mk(0,0,0,            32'hC,   32'hA2, 32'hC,  1,0, 3);
        vecs[6]  = mk(0,0,0,            32'h10,  32'hA3, 32'h10, 1,0, 4);
        vecs[7]  = mk(0,1,32'h103,      32'h100, 32'h0,  32'h0,  0,0, 4);
        vecs[8]  = mk(0,0,0,            32'h104, 32'hE0, 32'h104,1,0, 5);
        vecs[9]  = mk(1,1,32'h103,      32'h100, 32'h0,  32'h0,  0,0, 5);
        vecs[10] = mk(0,0,0,            32'h104, 32'hE0, 32'h104,1,0, 6);
        vecs[11] = mk(0,1,32'h18,       32'h18,  32'h0,  32'h0,  0,0, 6);
        vecs[12] = mk(0,0,0,            32'h1C,  32'hA6, 32'h1C, 1,0, 7);
        vecs[13] = mk(0,0,0,            32'h20,  32'hA7, 32'h20, 1,0, 8);
        vecs[14] = mk(0,0,0, T ? 32'h20 : 32'h24, TRAP, 32'h24,  1,T, 9);
        vecs[15] = T ? mk(0,0,0, 32'h20, 32'h0,  32'h0,  0,1, 9)
                     : mk(0,0,0, 32'h28, 32'hA9, 32'h28, 1,0, 10);
        vecs[16] = T ? mk(0,0,0, 32'h20, 32'h0,  32'h0,  0,1, 9)
                     : mk(0,0,0, 32'h2C, 32'hAA, 32'h2C, 1,0, 11);
        vecs[17] = mk(0,1,32'h40,       32'h40,  32'h0,  32'h0,  0,0, T ? 9 : 11);
        vecs[18] = mk(0,0,0,            32'h44,  32'hB0, 32'h44, 1,0, T ? 10 : 12);
        vecs[19] = mk(0,1,32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0, 0,0, T ? 10 : 12);
        vecs[20] = mk(0,0,0,            32'h0,   32'h4000009F, 32'h0, 1,0, T ? 11 : 13);

        reset         = 1'b0;
        stall_in      = 1'b0;
        redirect_in   = 1'b0;
        redirectPC_in = '0;
        #12;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            chk_all($sformatf("v%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].npc,
                    vecs[i].valid, vecs[i].halted, vecs[i].count);
        end

        // Walk into the trap again (halts when enabled), then reset mid-stall
        // with a redirect pending; nothing may survive the reset.
        step(0, 1, 32'h1C);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pre_reset_halted", {31'b0, halted_out}, {31'b0, T});
        step(1, 1, 32'h200);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("held_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        stall_in    = 1'b0;
        redirect_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0);
        chk_all("after_reset", 32'h4, 32'hA0, 32'h4, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the 32-bit DLX pipeline. Holds the program counter and drives the instruction-memory address. Latches the fetched word and its PC+4 into the IF/ID register consumed by `instruction_decode`. Handles stalls, taken-branch/jump redirects from later stages, and halts fetch after a trap instruction.

## Interface
Parameters:
- `SIZE`, 32: datapath width.
- `RESET_PC`, 32'h00000000: PC value loaded on reset.
- `NOP_INSTR`, 32'h00000000: word placed in IF/ID when squashed or empty.
- `TRAP_INSTR`, 32'h44000300: encoding that triggers a fetch halt.

Ports (bit order `[0:SIZE-1]`, bit 0 = MSB):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `stall_in` in 1: hazard stall from decode; holds the PC and IF/ID.
- `redirect_in` in 1: a taken branch or jump was resolved downstream.
- `redirectPC_in` in 32: target PC for the redirect.
- `imem_addr_out` out 32: instruction-memory address, equal to the current PC (combinational from the PC register).
- `imem_data_in` in 32: instruction word for `imem_addr_out`, returned in the same cycle.
- `instruction_out` out 32: IF/ID instruction, feeding `instruction_in` of decode.
- `nextPC_out` out 32: IF/ID PC+4, feeding `nextPC_in` of decode.
- `valid_out` out 1: the IF/ID register holds a real instruction.
- `halted_out` out 1: fetch is in the HALTED state.
- `fetch_count_out` out 32: number of valid instructions latched into IF/ID since reset.

## Operation
- Internal state: `pc` (32), IF/ID register, FSM state {RUN, HALTED}, and `fetch_count`.
- PC+4 uses a 32-bit adder. It wraps modulo 2^32: 32'hFFFFFFFC + 4 = 0.
- Redirect target has bits [30:31] forced to 0 (word-aligned).
- Per-edge priority: reset > redirect > stall > normal.
- **Redirect**, in any state, including while stalled:
  - pc <= aligned target.
  - IF/ID <= `NOP_INSTR`, valid_out <= 0, nextPC_out <= 0.
  - state <= RUN.
  - The wrong-path word fetched this cycle is discarded.
- **Stall**, with no redirect: pc, IF/ID, state and count all hold.
- **RUN, normal**:
  - IF/ID <= {imem_data_in, pc+4}, valid_out <= 1.
  - pc <= pc+4.
  - fetch_count increments.
- **RUN, fetched word == `TRAP_INSTR`** (normal advance only):
  - The trap is latched as a normal valid instruction.
  - pc holds at the trap address.
  - state <= HALTED.
- **HALTED, no redirect, no stall**:
  - IF/ID <= NOP, valid_out <= 0.
  - pc holds, count holds.
  - halted_out = 1.
- Exit from HALTED is only by redirect or by reset.
- fetch_count wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset values (asserted asynchronously):
  - pc = `RESET_PC`, so imem_addr_out = `RESET_PC`.
  - instruction_out = `NOP_INSTR`, nextPC_out = 0, valid_out = 0.
  - halted_out = 0, fetch_count_out = 0, state = RUN.
- Instruction latency:
  - The word at PC appears on instruction_out one edge after the address is presented.
  - The first valid instruction appears at the first rising edge after reset is deasserted.
- Redirect costs exactly one bubble: the target's word becomes valid at the second edge after the redirect edge.
- A stall asserted for N cycles holds outputs for exactly N edges. No instruction is lost or duplicated.
- Reset asserted mid-stall, mid-redirect, or in HALTED returns all state to its reset values with no pending action retained.
- All outputs except imem_addr_out are registered.

## Configuration
- `IF_TRAP_HALT_EN` defined:
  - The HALTED state and trap detection are compiled in, as described above.
- `IF_TRAP_HALT_EN` not defined:
  - No trap comparator and no HALTED state.
  - `TRAP_INSTR` is fetched like any other word and the PC keeps advancing.
  - halted_out is tied to 0.

## Test plan
- Reset with RESET_PC=0 and sequential memory words 0xA0,0xA1,… → imem_addr_out 0,4,8; instruction_out 0xA0,0xA1 with nextPC_out 4,8; valid_out=1 from the first edge; fetch_count_out 1,2,….
- Stall held 3 cycles at pc=8 → addr stays 8; instruction_out/nextPC_out unchanged for 3 edges; count unchanged; resumes with word@8 on release.
- Redirect with redirectPC_in=32'h00000103 while pc=0x10 → next addr 0x100; one NOP with valid_out=0; then word@0x100 with nextPC_out=0x104. Repeat with stall_in=1 simultaneously → same result.
- Word 32'h44000300 at 0x20 (macro on) → trap latched valid with nextPC_out=0x24; then halted_out=1, valid_out=0, addr stuck at 0x20; redirect to 0x40 → RUN, fetch resumes at 0x40.
- Same trap stimulus with macro off → halted_out=0; addr continues 0x24, 0x28.
- pc=32'hFFFFFFFC → next addr 0. Reset pulsed low mid-stall → all outputs return to their reset values asynchronously.
